// File: rtl/fp_pkg.sv
// Shared types and constants for the float accumulation sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fp_pkg;

  typedef enum logic [2:0] {
    ACCEPT,
    SEND_A,
    SEND_B,
    WAIT_Z,
    DONE
  } state_t;

  localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_QNAN     = 32'hFFC0_0000;

  // True for any NaN encoding: all-ones exponent with a nonzero mantissa.
  function automatic logic is_nan(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
  endfunction

endpackage

// File: rtl/fp_stb_ack_tx.sv
// Strobe/ack operand driver: holds data and strobe stable until the first ack.
// Latency: strobe rises the cycle after load; drops the cycle after ack is sampled.
// Backpressure: waits indefinitely for ack; ack seen while strobe is low is ignored.
module fp_stb_ack_tx (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_dat,
  input  logic        ack,
  output logic [31:0] dat,
  output logic        stb,
  output logic        done
);

  // Handshake completes only while our strobe is up, so a lingering ack is harmless.
  assign done = stb && ack;

  // Capture operand on load, release strobe after the first ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      dat <= 32'd0;
      stb <= 1'b0;
    end else if (load) begin
      dat <= load_dat;
      stb <= 1'b1;
    end else if (done) begin
      stb <= 1'b0;
    end
  end

endmodule

// File: rtl/fp_accum_seq.sv
// Frame accumulator: feeds one float addition at a time to an external adder, emits frame sum and count.
// Latency: per sample, adder latency plus 3 handshake cycles; result one cycle after the last sum returns.
// Backpressure: in_ready only in ACCEPT; result held on out_valid until out_ready. Option: NAN_STICKY_EN.
module fp_accum_seq
  import fp_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [31:0]      add_a,
  output logic             add_a_stb,
  input  logic             add_a_ack,
  output logic [31:0]      add_b,
  output logic             add_b_stb,
  input  logic             add_b_ack,
  input  logic [31:0]      add_z,
  input  logic             add_z_stb,
  output logic             add_z_ack,
  output logic [31:0]      out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_valid,
  input  logic             out_ready
);

  state_t            state, state_nxt;
  logic [31:0]       acc;
  logic [31:0]       sample_q;
  logic              last_q;
  logic [CNT_W-1:0]  count;
  logic              nan_q;
  logic              load_a, load_b, a_done, b_done, z_take;

`ifndef NAN_STICKY_EN
  assign nan_q = 1'b0;
`endif

  fp_stb_ack_tx u_tx_a (
    .clk      (clk),
    .rst      (rst),
    .load     (load_a),
    .load_dat (acc),
    .ack      (add_a_ack),
    .dat      (add_a),
    .stb      (add_a_stb),
    .done     (a_done)
  );

  fp_stb_ack_tx u_tx_b (
    .clk      (clk),
    .rst      (rst),
    .load     (load_b),
    .load_dat (sample_q),
    .ack      (add_b_ack),
    .dat      (add_b),
    .stb      (add_b_stb),
    .done     (b_done)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ACCEPT;
    else     state <= state_nxt;
  end

  // Next-state decode and single-cycle control pulses.
  always_comb begin
    state_nxt = state;
    in_ready  = (state == ACCEPT) && !rst;
    load_a    = 1'b0;
    load_b    = 1'b0;
    z_take    = 1'b0;
    case (state)
      ACCEPT: begin
        if (in_valid) begin
          if (nan_q) begin
            // Sum is already poisoned; only bookkeeping remains.
            state_nxt = in_last ? DONE : ACCEPT;
          end else begin
            load_a    = 1'b1;
            state_nxt = SEND_A;
          end
        end
      end
      SEND_A: begin
        if (a_done) begin
          load_b    = 1'b1;
          state_nxt = SEND_B;
        end
      end
      SEND_B: begin
        if (b_done) state_nxt = WAIT_Z;
      end
      WAIT_Z: begin
        if (add_z_stb && !add_z_ack) begin
          z_take    = 1'b1;
          state_nxt = last_q ? DONE : ACCEPT;
        end
      end
      DONE: begin
        if (out_valid && out_ready) state_nxt = ACCEPT;
      end
      default: state_nxt = ACCEPT;
    endcase
  end

  // Sample capture, running sum, counter, result ack and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= FP_POS_ZERO;
      sample_q  <= 32'd0;
      last_q    <= 1'b0;
      count     <= '0;
      add_z_ack <= 1'b0;
      out_sum   <= 32'd0;
      out_count <= '0;
      out_valid <= 1'b0;
`ifdef NAN_STICKY_EN
      nan_q     <= 1'b0;
`endif
    end else begin
      add_z_ack <= z_take;
      if ((state == ACCEPT) && in_valid) begin
        sample_q <= in_data;
        last_q   <= in_last;
        if (count != {CNT_W{1'b1}}) count <= count + CNT_W'(1);
      end
      if (z_take) begin
        acc <= add_z;
`ifdef NAN_STICKY_EN
        if (is_nan(add_z)) nan_q <= 1'b1;
`endif
      end
      if (state == DONE) begin
        if (!out_valid) begin
          out_sum   <= nan_q ? FP_QNAN : acc;
          out_count <= count;
          out_valid <= 1'b1;
        end else if (out_ready) begin
          out_valid <= 1'b0;
          acc       <= FP_POS_ZERO;
          count     <= '0;
`ifdef NAN_STICKY_EN
          nan_q     <= 1'b0;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_accum_seq.sv
// Bench for fp_accum_seq: behavioural adder responder, frame-sum scoreboard, directed frames.
// Latency: n/a.
// Backpressure: exercised via out_ready hold and varying adder ack/result delays.
module tb_fp_accum_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic        in_valid, in_last, in_ready;
  logic [31:0] add_a, add_b, add_z;
  logic        add_a_stb, add_a_ack, add_b_stb, add_b_ack, add_z_stb, add_z_ack;
  logic [31:0] out_sum;
  logic [15:0] out_count;
  logic        out_valid, out_ready;

  int total = 0;
  int bad   = 0;
  logic watch = 1'b0;
  int   a_rises = 0;

  typedef struct packed {
    logic [31:0] sum;
    logic [15:0] cnt;
  } frame_t;
  frame_t exp_q[$];

  always #5 clk = ~clk;

  fp_accum_seq #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .add_a(add_a), .add_a_stb(add_a_stb), .add_a_ack(add_a_ack),
    .add_b(add_b), .add_b_stb(add_b_stb), .add_b_ack(add_b_ack),
    .add_z(add_z), .add_z_stb(add_z_stb), .add_z_ack(add_z_ack),
    .out_sum(out_sum), .out_count(out_count), .out_valid(out_valid), .out_ready(out_ready)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic f_isnan(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
  endfunction

  // Single to double is exact for normals and zero.
  function automatic real s2r(input logic [31:0] s);
    logic [63:0] d;
    int e;
    if (s[30:23] == 8'h00) d = {s[31], 63'd0};
    else begin
      e = int'(s[30:23]) + 896;
      d = {s[31], e[10:0], s[22:0], 29'd0};
    end
    return $bitstoreal(d);
  endfunction

  // Double back to single; bench values are all exactly representable.
  function automatic logic [31:0] r2s(input real x);
    logic [63:0] d;
    int e;
    d = $realtobits(x);
    if (d[62:52] == 11'd0) return {d[63], 31'd0};
    e = int'(d[62:52]) - 896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    if (f_isnan(a) || f_isnan(b)) return 32'h7FC0_0000;
    return r2s(s2r(a) + s2r(b));
  endfunction

  // Adder responder: varying ack delay, lingering acks and result latency; shares rst.
  initial begin
    int rs, cnt, op;
    logic r_seen;
    logic [31:0] a_val, b_val;
    add_a_ack = 0; add_b_ack = 0; add_z_stb = 0; add_z = 0;
    rs = 0; cnt = 0; op = 0; a_val = 0; b_val = 0;
    forever begin
      @(posedge clk);
      r_seen = rst;
      #2;
      if (r_seen) begin
        rs = 0; cnt = 0; add_a_ack = 0; add_b_ack = 0; add_z_stb = 0;
      end else begin
        case (rs)
          0: begin
            add_a_ack = 0;
            if (add_a_stb) begin
              if (cnt >= op % 3) begin add_a_ack = 1; a_val = add_a; cnt = 0; rs = 1; end
              else cnt++;
            end
          end
          1: begin add_a_ack = op[0]; rs = 2; end
          2: begin
            add_a_ack = 0;
            if (add_b_stb) begin add_b_ack = 1; b_val = add_b; rs = 3; end
          end
          3: begin add_b_ack = op[1]; rs = 4; end
          4: begin
            add_b_ack = 0;
            if (cnt >= op % 4) begin add_z = fadd(a_val, b_val); add_z_stb = 1; cnt = 0; rs = 5; end
            else cnt++;
          end
          default: begin
            if (add_z_ack) begin add_z_stb = 0; op++; rs = 0; end
          end
        endcase
      end
    end
  end

  // Scoreboard: frame sum is the left fold of float additions from +0.0; checks every valid cycle.
  initial begin
    logic [31:0] run_sum, exp_sum;
    logic [15:0] run_cnt;
    logic run_nan, z_ack_prev, z_stb_prev, a_prev;
    frame_t f;
    run_sum = 0; run_cnt = 0; run_nan = 0; z_ack_prev = 0; z_stb_prev = 0; a_prev = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        run_sum = 0; run_cnt = 0; run_nan = 0;
        exp_q.delete();
      end else begin
        if (add_z_ack && !z_ack_prev) check("z_ack_needs_stb", {31'd0, z_stb_prev}, 32'd1);
        if (watch && add_a_stb && !a_prev) a_rises++;
        if (out_valid) begin
          if (exp_q.size() == 0) check("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
          else begin
            check("sb_out_sum", out_sum, exp_q[0].sum);
            check("sb_out_count", {16'd0, out_count}, {16'd0, exp_q[0].cnt});
            if (out_ready) void'(exp_q.pop_front());
          end
        end
        if (in_valid && in_ready) begin
          run_sum = fadd(run_sum, in_data);
          if (f_isnan(run_sum)) run_nan = 1;
          if (run_cnt != 16'hFFFF) run_cnt = run_cnt + 16'd1;
          if (in_last) begin
            exp_sum = run_sum;
`ifdef NAN_STICKY_EN
            if (run_nan) exp_sum = 32'hFFC0_0000;
`endif
            f.sum = exp_sum;
            f.cnt = run_cnt;
            exp_q.push_back(f);
            run_sum = 0; run_cnt = 0; run_nan = 0;
          end
        end
      end
      z_ack_prev = add_z_ack;
      z_stb_prev = add_z_stb;
      a_prev     = add_a_stb;
    end
  end

  task automatic send(input logic [31:0] d, input logic l);
    int n;
    n = 0;
    in_data = d; in_valid = 1; in_last = l;
    @(negedge clk);
    while (!in_ready && n < 400) begin @(negedge clk); n++; end
    if (!in_ready) check("send_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 0; in_last = 0;
  endtask

  task automatic wait_out(input string nm, input logic [31:0] es, input logic [15:0] ec);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 400) begin @(negedge clk); n++; end
    if (!out_valid) check({nm, "_timeout"}, {31'd0, out_valid}, 32'd1);
    else begin
      check({nm, "_sum"}, out_sum, es);
      check({nm, "_count"}, {16'd0, out_count}, {16'd0, ec});
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_sig_b(output logic seen);
    int n;
    n = 0;
    seen = 0;
    while (!seen && n < 400) begin @(negedge clk); seen = add_b_stb; n++; end
  endtask

  initial begin
    logic seen;
    int n;
    rst = 1; in_data = 0; in_valid = 0; in_last = 0; out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_a_stb", {31'd0, add_a_stb}, 32'd0);
    check("rst_b_stb", {31'd0, add_b_stb}, 32'd0);
    check("rst_z_ack", {31'd0, add_z_ack}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_sum", out_sum, 32'd0);
    check("rst_add_a", add_a, 32'd0);
    rst = 0;
    @(negedge clk);
    check("idle_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // 1.0 + 2.0 + 3.0
    send(32'h3F80_0000, 0); send(32'h4000_0000, 0); send(32'h4040_0000, 1);
    wait_out("f123", 32'h40C0_0000, 16'd3);
    // single sample comes back exactly
    send(32'h3FC0_0000, 1);
    wait_out("single", 32'h3FC0_0000, 16'd1);
    // cancellation gives positive zero
    send(32'h4020_0000, 0); send(32'hC020_0000, 1);
    wait_out("cancel", 32'h0000_0000, 16'd2);

    // downstream stall
    out_ready = 0;
    send(32'h3F80_0000, 0); send(32'h4000_0000, 0); send(32'h4040_0000, 1);
    wait_out("stall", 32'h40C0_0000, 16'd3);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("stall_valid", {31'd0, out_valid}, 32'd1);
      check("stall_sum", out_sum, 32'h40C0_0000);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1;
    @(posedge clk); #1;
    send(32'h4080_0000, 1);
    wait_out("after_stall", 32'h4080_0000, 16'd1);

    // reset in the middle of a frame
    send(32'h3F80_0000, 0);
    wait_sig_b(seen);
    check("reach_send_b", {31'd0, seen}, 32'd1);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    check("mid_rst_a_stb", {31'd0, add_a_stb}, 32'd0);
    check("mid_rst_b_stb", {31'd0, add_b_stb}, 32'd0);
    check("mid_rst_z_ack", {31'd0, add_z_ack}, 32'd0);
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 0;
    send(32'h3F80_0000, 1);
    wait_out("post_rst", 32'h3F80_0000, 16'd1);

    // NaN in the first sample
    send(32'h7FC0_0000, 0);
    n = 0;
    while (!add_z_ack && n < 400) begin @(negedge clk); n++; end
    check("nan_first_result", {31'd0, add_z_ack}, 32'd1);
    watch = 1;
    @(posedge clk); #1;
    send(32'h3F80_0000, 0); send(32'h4000_0000, 1);
`ifdef NAN_STICKY_EN
    wait_out("nan", 32'hFFC0_0000, 16'd3);
    watch = 0;
    check("nan_a_stb_rises", a_rises, 32'd0);
`else
    wait_out("nan", 32'h7FC0_0000, 16'd3);
    watch = 0;
    check("nan_a_stb_rises", a_rises, 32'd2);
`endif

    repeat (5) @(posedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

endmodule
